// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 core types and constants
package riscv_pkg;

    // Writeback-source select carried down the pipe with each instruction.
    typedef enum logic [1:0] {
        from_ALU     = 2'd0,
        from_DataMem = 2'd1,
        from_PC4     = 2'd2,
        from_Imm     = 2'd3
    } MReg_sel_e;

    // Hazard unit FSM: free running, or counting down a load-use bubble.
    typedef enum logic {
        HZ_RUN = 1'b0,
        HZ_LU  = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_X0       = 5'd0;
    localparam int         LOAD_LAT_MAX = 7;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
// Ports: clk, rst (sync, active high), inc (count enable), count (current value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Stick at all-ones rather than wrapping back to zero.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard detection, stall/flush control and counters
// Inputs : clk, rst (sync, active high), IF/ID source regs (id_rs1, id_rs2, id_uses_rs2),
//          ID/EX destination info (ex_rd, ex_regwrite, ex_mreg), ex_redirect, mem_busy.
// Outputs: Stall, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write,
//          stall_cycles / flush_events saturating counters.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  MReg_sel_e        ex_mreg,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             Stall,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Remaining bubbles after the first one of a load-use stall.
    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

    hz_state_e  state_q, state_d;
    logic [2:0] lu_cnt_q, lu_cnt_d;
    logic       load_hz;

    assign load_hz = ex_regwrite
                   && (ex_mreg == from_DataMem)
                   && (ex_rd != REG_X0)
                   && ((id_rs1 == ex_rd) || (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d      = state_q;
        lu_cnt_d     = lu_cnt_q;
        Stall        = 1'b0;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Write = 1'b1;

        if (rst) begin
            // Defaults only; the register reset puts the FSM back in HZ_RUN.
        end else if (mem_busy) begin
            // Whole pipe frozen; redirect/load-use are re-evaluated afterwards
            // because the stages holding them have not moved.
            Stall        = 1'b1;
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
        end else if (ex_redirect) begin
            // Squashing the younger instructions also cancels any pending bubble.
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            state_d     = HZ_RUN;
            lu_cnt_d    = 3'd0;
        end else if (state_q == HZ_LU) begin
            Stall       = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            lu_cnt_d    = lu_cnt_q - 3'd1;
            if (lu_cnt_q == 3'd1) begin
                state_d = HZ_RUN;
            end
        end else if (load_hz) begin
            Stall       = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d  = HZ_LU;
                lu_cnt_d = LU_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HZ_RUN;
            lu_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (Stall),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (IF_ID_Flush),
        .count (flush_events)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit
module tb_hazard_unit;
    import riscv_pkg::*;

    localparam int C_DEF = 0;
    localparam int C_FRZ = 1;
    localparam int C_RED = 2;
    localparam int C_LU  = 3;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs2, ex_regwrite, ex_redirect, mem_busy;
    MReg_sel_e  ex_mreg;

    // {Stall, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write}
    logic [5:0]  o1, o3, o4;
    logic [15:0] sc1, fe1, sc3, fe3;
    logic [3:0]  sc4, fe4;

    hazard_unit #(.LOAD_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_mreg(ex_mreg), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy), .Stall(o1[5]), .PCWrite(o1[4]), .IF_ID_Write(o1[3]),
        .IF_ID_Flush(o1[2]), .ID_EX_Flush(o1[1]), .EX_MEM_Write(o1[0]),
        .stall_cycles(sc1), .flush_events(fe1)
    );

    hazard_unit #(.LOAD_LAT(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_mreg(ex_mreg), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy), .Stall(o3[5]), .PCWrite(o3[4]), .IF_ID_Write(o3[3]),
        .IF_ID_Flush(o3[2]), .ID_EX_Flush(o3[1]), .EX_MEM_Write(o3[0]),
        .stall_cycles(sc3), .flush_events(fe3)
    );

    hazard_unit #(.LOAD_LAT(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_mreg(ex_mreg), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy), .Stall(o4[5]), .PCWrite(o4[4]), .IF_ID_Write(o4[3]),
        .IF_ID_Flush(o4[2]), .ID_EX_Flush(o4[1]), .EX_MEM_Write(o4[0]),
        .stall_cycles(sc4), .flush_events(fe4)
    );

    typedef struct {
        int    dut;
        int    cls;
        int    sc;
        int    fe;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [5:0] cls_vec(input int c);
        case (c)
            C_FRZ:   return 6'b100000;
            C_RED:   return 6'b011111;
            C_LU:    return 6'b100011;
            default: return 6'b011001;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [5:0] o;
        int         sc_v, fe_v;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                1:       begin o = o1; sc_v = int'(sc1); fe_v = int'(fe1); end
                3:       begin o = o3; sc_v = int'(sc3); fe_v = int'(fe3); end
                default: begin o = o4; sc_v = int'(sc4); fe_v = int'(fe4); end
            endcase
            chk({e.tag, ".ctl"}, int'(o), int'(cls_vec(e.cls)));
            if (e.sc >= 0) chk({e.tag, ".stall_cycles"}, sc_v, e.sc);
            if (e.fe >= 0) chk({e.tag, ".flush_events"}, fe_v, e.fe);
        end
    end

    task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic rw,
                        input MReg_sel_e m, input logic redir, input logic busy,
                        input int dut, input int cls, input int sc, input int fe,
                        input string tag);
        exp_t e;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; ex_rd = rd;
        ex_regwrite = rw; ex_mreg = m; ex_redirect = redir; mem_busy = busy;
        e.dut = dut; e.cls = cls; e.sc = sc; e.fe = fe; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r, input logic busy, input logic redir,
                        input int dut, input int cls, input int sc, input int fe,
                        input string tag);
        step(r, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, from_ALU, redir, busy, dut, cls, sc, fe, tag);
    endtask

    task automatic lu_in(input int dut, input int cls, input int sc, input string tag);
        step(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, from_DataMem, 1'b0, 1'b0, dut, cls, sc, -1, tag);
    endtask

    initial begin
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0; ex_rd = '0;
        ex_regwrite = 1'b0; ex_mreg = from_ALU; ex_redirect = 1'b0; mem_busy = 1'b0;
        @(posedge clk);
        #1;

        // LOAD_LAT = 1 instance
        step(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, from_DataMem, 1'b0, 1'b0, 1, C_DEF, -1, -1, "rst_default");
        idle(1'b0, 1'b0, 1'b0, 1, C_DEF, 0, 0, "after_rst");
        lu_in(1, C_LU, 0, "lu1");
        idle(1'b0, 1'b0, 1'b0, 1, C_DEF, 1, -1, "lu1_done");
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, from_DataMem, 1'b0, 1'b0, 1, C_DEF, 1, -1, "rd_x0");
        step(1'b0, 5'd1, 5'd5, 1'b0, 5'd5, 1'b1, from_DataMem, 1'b0, 1'b0, 1, C_DEF, 1, -1, "rs2_unused");
        step(1'b0, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, from_DataMem, 1'b0, 1'b0, 1, C_LU, 1, -1, "rs2_used");
        step(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, from_ALU, 1'b0, 1'b0, 1, C_DEF, 2, -1, "alu_src");
        step(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, from_DataMem, 1'b1, 1'b0, 1, C_RED, 2, 0, "redir_over_lu");
        idle(1'b0, 1'b0, 1'b0, 1, C_DEF, 2, 1, "redir_done");

        // LOAD_LAT = 3 instance: freeze overlapping the stall, then redirect inside HZ_LU
        idle(1'b1, 1'b0, 1'b0, 3, C_DEF, -1, -1, "rst3");
        idle(1'b0, 1'b0, 1'b0, 3, C_DEF, 0, 0, "rst3_done");
        lu_in(3, C_LU, 0, "lu3_s1");
        idle(1'b0, 1'b1, 1'b0, 3, C_FRZ, 1, -1, "lu3_frz1");
        idle(1'b0, 1'b1, 1'b0, 3, C_FRZ, 2, -1, "lu3_frz2");
        idle(1'b0, 1'b0, 1'b0, 3, C_LU, 3, -1, "lu3_s2");
        idle(1'b0, 1'b0, 1'b0, 3, C_LU, 4, -1, "lu3_s3");
        idle(1'b0, 1'b0, 1'b0, 3, C_DEF, 5, -1, "lu3_end");
        lu_in(3, C_LU, 5, "lu3b_s1");
        idle(1'b0, 1'b0, 1'b0, 3, C_LU, 6, -1, "lu3b_s2");
        idle(1'b0, 1'b0, 1'b1, 3, C_RED, 7, 0, "lu3b_redir");
        idle(1'b0, 1'b0, 1'b0, 3, C_DEF, 7, 1, "lu3b_run");

        // LOAD_LAT = 4, CNT_W = 4 instance: reset mid-stall, then saturation
        idle(1'b1, 1'b0, 1'b0, 4, C_DEF, -1, -1, "rst4");
        idle(1'b0, 1'b0, 1'b0, 4, C_DEF, 0, 0, "rst4_done");
        lu_in(4, C_LU, 0, "lu4_s1");
        idle(1'b1, 1'b0, 1'b0, 4, C_DEF, 1, -1, "lu4_rst");
        idle(1'b0, 1'b0, 1'b0, 4, C_DEF, 0, 0, "lu4_after_rst");
        idle(1'b0, 1'b0, 1'b0, 4, C_DEF, 0, 0, "lu4_run");
        for (int i = 0; i < 20; i++) begin
            idle(1'b0, 1'b1, 1'b0, 4, C_FRZ, (i < 15) ? i : 15, -1, $sformatf("sat_%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 1'b0, 1'b0, 4, C_DEF, 15, 0, $sformatf("sat_hold_%0d", i));
        end

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Producer end of the `Stall` line into the ID-stage control decoder. Also drives the pipeline-register write enables and the flush controls of the 5-stage RV32 core.
- Detects three conditions and resolves them in this priority order:
  - data-memory wait, which freezes the pipe;
  - taken branch or jump resolved in EX, which squashes IF/ID and ID/EX;
  - load-use dependency, which holds PC and IF/ID for `LOAD_LAT` cycles and bubbles ID/EX.
- Keeps saturating stall and flush performance counters.

Parameters:
- `LOAD_LAT`, default 1: load-use bubble cycles. Legal range 1..7.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk`  in  1  clock. Rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs1`  in  5  rs1 of the instruction in IF/ID.
- `id_rs2`  in  5  rs2 of the instruction in IF/ID.
- `id_uses_rs2`  in  1  IF/ID instruction reads rs2 (R, S, B types).
- `ex_rd`  in  5  destination register of the instruction in ID/EX.
- `ex_regwrite`  in  1  ID/EX `RegWrite`.
- `ex_mreg`  in  `MReg_sel_e`  ID/EX writeback-source select.
- `ex_redirect`  in  1  EX has resolved a taken branch (`PC_BEQ` with equal operands) or a jump (`PC_J`).
- `mem_busy`  in  1  data memory cannot complete this cycle.
- `Stall`  out  1  to the control decoder. Forces `RegWrite`=0 and `DataMem_RW`=Read.
- `PCWrite`  out  1  PC register enable.
- `IF_ID_Write`  out  1  IF/ID register enable.
- `IF_ID_Flush`  out  1  clear IF/ID to a NOP.
- `ID_EX_Flush`  out  1  clear ID/EX to a bubble.
- `EX_MEM_Write`  out  1  EX/MEM and MEM/WB enable.
- `stall_cycles`  out  `CNT_W`  saturating count of cycles with `Stall`=1.
- `flush_events`  out  `CNT_W`  saturating count of redirect cycles.

Behaviour:
- State: FSM {`HZ_RUN`, `HZ_LU`}, a 3-bit countdown `lu_cnt`, and the two counters. All outputs other than the counters are combinational from state and inputs, in the same cycle.
- `load_hz` = `ex_regwrite` & (`ex_mreg`==`from_DataMem`) & (`ex_rd`!=0) & ((`id_rs1`==`ex_rd`) | (`id_uses_rs2` & (`id_rs2`==`ex_rd`))).
- Default (no condition active): `Stall`=0, `PCWrite`=1, `IF_ID_Write`=1, `EX_MEM_Write`=1, both flushes 0.
- Freeze (`mem_busy`=1, in any state):
  - `Stall`=1, `PCWrite`=0, `IF_ID_Write`=0, `EX_MEM_Write`=0, flushes 0.
  - FSM and `lu_cnt` hold.
  - `ex_redirect` and `load_hz` are ignored. They are re-evaluated once `mem_busy` drops, because the stages are held.
- Redirect (`mem_busy`=0, `ex_redirect`=1, in any state):
  - `IF_ID_Flush`=1, `ID_EX_Flush`=1, `PCWrite`=1, `Stall`=0.
  - Next state is `HZ_RUN` with `lu_cnt`=0.
  - Redirect beats a simultaneous `load_hz`.
- Load-use in `HZ_RUN` (`mem_busy`=0, `ex_redirect`=0, `load_hz`=1):
  - `Stall`=1, `PCWrite`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1.
  - If `LOAD_LAT`>1: go to `HZ_LU` with `lu_cnt`=`LOAD_LAT`-1. Otherwise remain in `HZ_RUN`.
- `HZ_LU` (`mem_busy`=0, `ex_redirect`=0):
  - Same outputs as the load-use case, regardless of `load_hz`.
  - `lu_cnt` decrements each cycle. The cycle in which `lu_cnt`==1 is the last stall cycle; the next state is `HZ_RUN`.
- Stall accounting: total `Stall` cycles per load-use = `LOAD_LAT` + the number of frozen cycles overlapping it.
- Counters:
  - `stall_cycles` increments on every cycle with `Stall`=1.
  - `flush_events` increments on every cycle with `IF_ID_Flush`=1.
  - Both saturate at all-ones and never wrap.
- Reset:
  - Synchronous. Next state is `HZ_RUN`, `lu_cnt`=0, both counters 0.
  - Reset asserted mid-`HZ_LU` aborts the stall.
  - While `rst`=1, outputs take the default values and the counters do not increment.

Decomposition:
- Add to `riscv_pkg`:
  - `hz_state_e` {`HZ_RUN`, `HZ_LU`};
  - `REG_X0` = 5'd0;
  - `LOAD_LAT_MAX` = 7.
- Reuse the existing `MReg_sel_e` from the package.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rst`, `inc`, `count`), instantiated twice.

Test Plan:
- `LOAD_LAT`=1; `ex_rd`=5, `ex_mreg`=`from_DataMem`, `ex_regwrite`=1, `id_rs1`=5 → exactly 1 cycle of `Stall`=1, `PCWrite`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1; `stall_cycles`=1.
- `ex_rd`=0 with `id_rs1`=0 → no stall. `id_rs2`=5, `ex_rd`=5, `id_uses_rs2`=0 → no stall; the same with `id_uses_rs2`=1 → stall. `ex_mreg`=`from_ALU` → no stall.
- `ex_redirect`=1 together with `load_hz`=1 → `IF_ID_Flush`=`ID_EX_Flush`=1, `Stall`=0, `PCWrite`=1; `flush_events` goes 0→1; next state `HZ_RUN`.
- `LOAD_LAT`=3, `mem_busy`=1 on the 2nd stall cycle for 2 cycles → 5 consecutive `Stall` cycles; `EX_MEM_Write`=0 only in the 2 frozen cycles; `stall_cycles`=5.
- `CNT_W`=4 with 20 forced stall cycles → `stall_cycles`=15 and holds there.
- `rst` asserted during `HZ_LU` (`LOAD_LAT`=4, on the 2nd stall cycle) → next cycle `Stall`=0, counters 0, `HZ_RUN`.
